// File: rtl/reset_sequencer.sv
// Reset sequencer: merges synchronised, debounced reset sources and PLL lock into
// a stretched SoC reset, keeping sticky per-source cause bits and a RUN-exit count.
module reset_sequencer #(
  parameter int unsigned           NUM_SOURCES     = 4,
  parameter int unsigned           SYNC_STAGES     = 2,
  parameter int unsigned           DEBOUNCE_CYCLES = 16,
  parameter int unsigned           STRETCH_CYCLES  = 255,
  parameter logic [NUM_SOURCES-1:0] EDGE_MASK      = 4'b0001,
  parameter logic [NUM_SOURCES-1:0] INVERT_MASK    = 4'b0000
) (
  input  logic                   io_mainClk,
  input  logic                   io_asyncResetN,
  input  logic                   io_pllLocked,
  input  logic [NUM_SOURCES-1:0] io_resetSources,
  input  logic                   io_causeClear,
  output logic                   io_resetOut,
  output logic                   io_ready,
  output logic [NUM_SOURCES:0]   io_resetCause,
  output logic [7:0]             io_resetCount
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned ST_W = $clog2(STRETCH_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STRETCH_CYCLES - 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t                                  state_r;
  logic [ST_W-1:0]                         stretch_cnt_r;
  logic [NUM_SOURCES-1:0][SYNC_STAGES-1:0] src_sync_r;
  logic [SYNC_STAGES-1:0]                  pll_sync_r;
  logic [NUM_SOURCES-1:0][DB_W-1:0]        deb_cnt_r;
  logic [NUM_SOURCES-1:0]                  deb_r;
  logic [NUM_SOURCES-1:0]                  deb_prev_r;
  logic [NUM_SOURCES:0]                    cause_r;
  logic [7:0]                              count_r;
  logic                                    reset_out_r;
  logic                                    ready_r;

  logic [NUM_SOURCES-1:0] raw_s;
  logic [NUM_SOURCES-1:0] sync_out_s;
  logic [NUM_SOURCES-1:0] level_trig_s;
  logic [NUM_SOURCES-1:0] edge_pulse_s;
  logic                   pll_loss_s;
  logic                   any_level_s;
  logic                   any_edge_s;

  // Trigger decode from the debounced levels and the synchronised PLL lock
  always_comb begin
    raw_s        = io_resetSources ^ INVERT_MASK;
    sync_out_s   = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      sync_out_s[i] = src_sync_r[i][SYNC_STAGES-1];
    end
    level_trig_s = deb_r & ~EDGE_MASK;
    edge_pulse_s = deb_prev_r & ~deb_r & EDGE_MASK;
    pll_loss_s   = ~pll_sync_r[SYNC_STAGES-1];
    any_level_s  = (|level_trig_s) | pll_loss_s;
    any_edge_s   = |edge_pulse_s;
  end

  // Synchronisers and per-source debouncers
  always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
    if (!io_asyncResetN) begin
      src_sync_r <= '0;
      pll_sync_r <= '0;
      deb_cnt_r  <= '0;
      deb_r      <= '0;
      deb_prev_r <= '0;
    end else begin
      pll_sync_r <= {pll_sync_r[SYNC_STAGES-2:0], io_pllLocked};
      deb_prev_r <= deb_r;
      for (int i = 0; i < NUM_SOURCES; i++) begin
        src_sync_r[i] <= {src_sync_r[i][SYNC_STAGES-2:0], raw_s[i]};
        if (sync_out_s[i] != deb_r[i]) begin
          if (deb_cnt_r[i] == DB_LAST) begin
            deb_r[i]     <= ~deb_r[i];
            deb_cnt_r[i] <= '0;
          end else begin
            deb_cnt_r[i] <= deb_cnt_r[i] + DB_W'(1);
          end
        end else begin
          deb_cnt_r[i] <= '0;
        end
      end
    end
  end

  // Sequencer FSM with registered reset/ready outputs and saturating exit count
  always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
    if (!io_asyncResetN) begin
      state_r       <= HOLD;
      stretch_cnt_r <= '0;
      reset_out_r   <= 1'b1;
      ready_r       <= 1'b0;
      count_r       <= 8'd0;
    end else begin
      reset_out_r <= (state_r != RUN);
      ready_r     <= (state_r == RUN);
      if (any_level_s) begin
        state_r       <= HOLD;
        stretch_cnt_r <= '0;
      end else if (any_edge_s) begin
        state_r       <= STRETCH;
        stretch_cnt_r <= '0;
      end else begin
        case (state_r)
          HOLD: begin
            state_r       <= STRETCH;
            stretch_cnt_r <= '0;
          end
          STRETCH: begin
            if (stretch_cnt_r == ST_LAST) begin
              state_r       <= RUN;
              stretch_cnt_r <= '0;
            end else begin
              stretch_cnt_r <= stretch_cnt_r + ST_W'(1);
            end
          end
          RUN: begin
            state_r       <= RUN;
            stretch_cnt_r <= '0;
          end
          default: begin
            state_r       <= HOLD;
            stretch_cnt_r <= '0;
          end
        endcase
      end
      if ((state_r == RUN) && (any_level_s || any_edge_s) && (count_r != 8'hFF)) begin
        count_r <= count_r + 8'd1;
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Sticky cause bits; a trigger in the clearing cycle still lands
  always_ff @(posedge io_mainClk or negedge io_asyncResetN) begin
    if (!io_asyncResetN) begin
      cause_r <= '0;
    end else begin
      cause_r <= (io_causeClear ? '0 : cause_r) | {pll_loss_s, level_trig_s | edge_pulse_s};
    end
  end

  assign io_resetOut   = reset_out_r;
  assign io_ready      = ready_r;
  assign io_resetCause = cause_r;
  assign io_resetCount = count_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-up, level/edge triggers, glitch
// rejection, PLL loss with cause clear, stretch restart and count saturation.
module tb_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic       pll;
  logic [3:0] src;
  logic       clr;
  logic       reset_out;
  logic       ready;
  logic [4:0] cause;
  logic [7:0] count;

  int total_cnt;
  int bad_cnt;

  reset_sequencer #(
    .NUM_SOURCES    (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .STRETCH_CYCLES (8),
    .EDGE_MASK      (4'b0001),
    .INVERT_MASK    (4'b0000)
  ) dut (
    .io_mainClk     (clk),
    .io_asyncResetN (rst_n),
    .io_pllLocked   (pll),
    .io_resetSources(src),
    .io_causeClear  (clr),
    .io_resetOut    (reset_out),
    .io_ready       (ready),
    .io_resetCause  (cause),
    .io_resetCount  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int timeouts;
    int w;
    total_cnt = 0;
    bad_cnt   = 0;
    timeouts  = 0;
    rst_n = 1'b0;
    pll   = 1'b1;
    src   = 4'b0000;
    clr   = 1'b0;

    // 1: power-up hold and release
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("pu_hold_rst", reset_out, 1);
      check_eq("pu_hold_rdy", ready, 0);
    end
    check_eq("pu_hold_cause", cause, 0);
    check_eq("pu_hold_count", count, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check_eq("pu_release", reset_out, (k < 12) ? 1 : 0);
    end
    check_eq("pu_ready", ready, 1);
    check_eq("pu_cause", cause, 5'b10000);
    check_eq("pu_count", count, 0);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("clr_cause", cause, 0);

    // 2: edge source 0 falling edge
    src = 4'b0001;
    for (int k = 0; k < 10; k++) tick();
    src = 4'b0000;
    for (int k = 1; k <= 17; k++) begin
      tick();
      check_eq("edge_rst", reset_out, (k >= 8 && k <= 15) ? 1 : 0);
    end
    check_eq("edge_cause", cause, 5'b00001);
    check_eq("edge_count", count, 1);
    check_eq("edge_ready", ready, 1);

    // 3: short glitch on level source 1
    src = 4'b0010;
    for (int k = 0; k < 3; k++) tick();
    src = 4'b0000;
    for (int k = 0; k < 15; k++) begin
      tick();
      check_eq("glitch_rst", reset_out, 0);
    end
    check_eq("glitch_cause", cause, 5'b00001);
    check_eq("glitch_count", count, 1);

    // 4: level source 1 held 20 cycles
    src = 4'b0010;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 20) src = 4'b0000;
      check_eq("level_rst", reset_out, (k >= 8 && k <= 35) ? 1 : 0);
    end
    check_eq("level_cause", cause, 5'b00011);
    check_eq("level_count", count, 2);

    // 5: PLL loss with cause clear in the landing cycle
    pll = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 2) clr = 1'b1;
      if (k == 3) begin
        clr = 1'b0;
        check_eq("pll_cause", cause, 5'b10000);
        check_eq("pll_count", count, 3);
      end
      if (k == 5) pll = 1'b1;
      check_eq("pll_rst", reset_out, (k >= 4 && k <= 16) ? 1 : 0);
    end

    // 6: repeated edges keep stretch alive
    src = 4'b0001;
    for (int k = 1; k <= 55; k++) begin
      tick();
      src[0] = (k <= 36) && ((k % 8) < 4);
      check_eq("restart_rst", reset_out, (k >= 12 && k <= 51) ? 1 : 0);
    end
    check_eq("restart_count", count, 4);

    // count saturation across 300 RUN exits
    for (int n = 0; n < 300; n++) begin
      pll = 1'b0;
      tick();
      pll = 1'b1;
      w = 0;
      while (ready !== 1'b0 && w < 10) begin
        tick();
        w++;
      end
      if (w >= 10) timeouts++;
      w = 0;
      while (ready !== 1'b1 && w < 20) begin
        tick();
        w++;
      end
      if (w >= 20) timeouts++;
      if (n == 99) check_eq("sat_mid_count", count, 104);
    end
    check_eq("sat_timeouts", timeouts, 0);
    check_eq("sat_count", count, 255);

    // async reset mid-STRETCH
    pll = 1'b0;
    tick();
    pll = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check_eq("mid_stretch_rst", reset_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("areset_rst", reset_out, 1);
    check_eq("areset_rdy", ready, 0);
    check_eq("areset_cause", cause, 0);
    check_eq("areset_count", count, 0);
    tick();
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
